// File: rtl/rf16b_clk_en.sv
// rf16b_clk_en: WIDTH-bit register on the falling edge of clk_n with sync reset and load enable
module rf16b_clk_en #(
  parameter int unsigned WIDTH = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk_n,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);
  logic [WIDTH-1:0] q_q, q_d;
  // Reset outranks the enable; a low enable selects the stored word, so X on D cannot reach it
  always_comb q_d = rst ? RESET_VALUE : clk_en ? D : q_q;
  always_ff @(negedge clk_n) q_q <= q_d;
  assign Q = q_q;
endmodule

// File: tb/tb_rf16b_clk_en.sv
// tb_rf16b_clk_en: directed scoreboard bench for the falling-edge enabled register
module tb_rf16b_clk_en;
  logic        clk_n = 1'b0;
  logic        rst = 1'b0;
  logic        clk_en = 1'b0;
  logic [15:0] D = 'x;
  logic [15:0] Q;
  int          checks = 0;
  int          failures = 0;
  bit          done = 1'b0;

  typedef struct {
    logic [15:0] exp;
    bit          chk;
    string       name;
  } exp_t;

  exp_t sb[$];

  rf16b_clk_en #(.WIDTH(16), .RESET_VALUE(16'h0000)) dut (
    .clk_n (clk_n),
    .rst   (rst),
    .clk_en(clk_en),
    .D     (D),
    .Q     (Q)
  );

  always #10 clk_n = ~clk_n;

  // One scoreboard entry is pushed per falling edge; the monitor pops one per falling edge
  task automatic step(input logic r, input logic e, input logic [15:0] d,
                      input logic [15:0] exp, input bit chk, input string name);
    @(posedge clk_n);
    #3;
    rst = r;
    clk_en = e;
    D = d;
    sb.push_back('{exp, chk, name});
  endtask

  logic [15:0] last_exp;
  bit          last_known = 1'b0;
  string       last_name = "";

  initial begin
    forever begin
      @(negedge clk_n);
      #1;
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        if (e.chk) begin
          checks++;
          if (Q !== e.exp) begin
            failures++;
            $display("FAIL %s: Q=%h expected %h at %0t", e.name, Q, e.exp, $time);
          end
          last_exp = e.exp;
          last_known = 1'b1;
          last_name = e.name;
        end
      end
    end
  end

  // Rising edges must leave Q alone
  initial begin
    forever begin
      @(posedge clk_n);
      #1;
      if (last_known && !done) begin
        checks++;
        if (Q !== last_exp) begin
          failures++;
          $display("FAIL rise_hold(%s): Q=%h expected %h at %0t", last_name, Q, last_exp, $time);
        end
      end
    end
  end

  initial begin
    step(0, 0, 'x, 'x, 0, "pre_reset");
    step(0, 0, 'x, 'x, 0, "pre_reset");
    step(1, 0, 'x, 16'h0000, 1, "reset");
    step(0, 0, 16'h0000, 16'h0000, 1, "hold0");
    step(0, 0, 16'h1111, 16'h0000, 1, "hold1");
    step(0, 0, 16'h1111, 16'h0000, 1, "hold2");
    step(0, 0, 'x, 16'h0000, 1, "hold_dx");
    step(0, 1, 16'h1111, 16'h1111, 1, "load_1111");
    step(0, 1, 16'h2222, 16'h2222, 1, "load_2222");
    step(0, 1, 16'h4444, 16'h4444, 1, "load_4444");
    step(0, 1, 16'h8888, 16'h8888, 1, "load_8888");
    step(0, 1, 16'hcccc, 16'hcccc, 1, "load_cccc");
    step(0, 1, 16'hffff, 16'hffff, 1, "load_ffff");
    for (int i = 0; i < 5; i++) step(0, 1, 16'hffff, 16'hffff, 1, "idle_ffff");
    // Enable raised just after a falling edge with D=0, then D=1111 before the next one
    step(0, 0, 16'h0000, 16'hffff, 1, "en_off");
    @(negedge clk_n);
    #3;
    clk_en = 1'b1;
    D = 16'h0000;
    step(0, 1, 16'h1111, 16'h1111, 1, "late_en_1111");
    step(0, 1, 16'hffff, 16'hffff, 1, "reload_ffff");
    step(1, 1, 16'h5a5a, 16'h0000, 1, "rst_over_en");
    step(0, 1, 16'h5a5a, 16'h5a5a, 1, "rst_release_load");
    // Reset pulse that falls entirely between two falling edges
    step(0, 0, 16'h1234, 16'h5a5a, 1, "pre_pulse");
    @(negedge clk_n);
    #3;
    rst = 1'b1;
    sb.push_back('{16'h5a5a, 1'b1, "mid_rst_pulse"});
    #14;
    rst = 1'b0;
    step(1, 0, 16'h1234, 16'h0000, 1, "rst_across_edge");
    step(0, 0, 16'h9999, 16'h0000, 1, "post_rst_hold");
    step(0, 1, 16'ha5a5, 16'ha5a5, 1, "final_load");
    step(0, 0, 16'h0000, 16'ha5a5, 1, "final_hold");
    @(negedge clk_n);
    #5;
    done = 1'b1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
